uart_rs232_rx: RTL and testbench
================================

Name: uart_rs232_rx

Overview:
- UART receiver. Deserialises an asynchronous RS-232 line (8N1 by default) into parallel bytes.
- Sits at the host-link ingress of the DDS design, downstream of the PC/USB-serial bridge.
- Delivers command bytes to the control logic through a one-cycle valid strobe.
- Complements the existing UART transmitter: same bit-timing derivation, same parameter set, so TX and RX cores built with identical parameters interoperate.

Parameters:
- BIT_RATE, 9600: baud rate in bits/s.
- CLK_HZ, 48_000_000: system clock frequency in Hz.
- PAYLOAD_BITS, 8: data bits per frame.
- STOP_BITS, 1: stop bits expected; only the first is checked, the rest are treated as idle.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset, asynchronous assert, active-low.
- uart_rxd  input  1  asynchronous serial line; idles high.
- uart_rx_en  input  1  receiver enable; when low, the FSM stays in IDLE.
- uart_rx_break  output  1  one-cycle framing-error strobe (stop bit sampled low).
- uart_rx_valid  output  1  one-cycle strobe: uart_rx_data holds a new byte.
- uart_rx_data  output  PAYLOAD_BITS  last received payload, LSB first on the line.
- uart_rx_busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-low.
- Reset values:
  - uart_rx_data = 0, uart_rx_valid = 0, uart_rx_break = 0, uart_rx_busy = 0.
  - Both synchroniser flops = 1; edge-history flop = 1; counters = 0; state = IDLE.
- Timing:
  - CYCLES_PER_BIT = (1e9/BIT_RATE)/(1e9/CLK_HZ), integer division at each step, same as the transmitter.
  - HALF_BIT = CYCLES_PER_BIT/2.
  - Cycle counter width = 1 + clog2(CYCLES_PER_BIT).
  - Bit counter is 4 bits, so PAYLOAD_BITS must be ≤ 15.
- Input conditioning: uart_rxd passes through a 2-FF synchroniser. A falling edge is history = 1 and synchronised value = 0.
- FSM:
  - IDLE:
    - Counters held at 0.
    - Falling edge with uart_rx_en = 1 → START.
    - With uart_rx_en = 0, stays in IDLE.
  - START:
    - Count to HALF_BIT, then sample.
    - Sample = 0 → RECV, cycle counter cleared.
    - Sample = 1 → glitch, return to IDLE with no strobe.
  - RECV:
    - Every CYCLES_PER_BIT cycles, sample and shift right into the shift register; the new bit enters at the MSB. Bit counter increments.
    - After PAYLOAD_BITS samples → STOP.
  - STOP:
    - After CYCLES_PER_BIT cycles, sample the line.
    - Sample = 1: uart_rx_data ← shift register and uart_rx_valid = 1 for exactly one cycle, both in the cycle after the sample.
    - Sample = 0: uart_rx_break = 1 for one cycle; uart_rx_data unchanged.
    - Either way → IDLE on that same edge.
- Back-to-back frames: returning to IDLE mid stop-bit allows a start edge from the next frame to be accepted immediately.
- After a break: IDLE needs a 1→0 edge, so a line stuck low never restarts the FSM.
- uart_rx_data holds its value until the next valid frame.
- uart_rx_en deasserted mid-frame: the current frame completes; the enable is only examined in IDLE.
- Reset asserted mid-frame: everything returns to reset values immediately; no strobe is produced.
- Latency: uart_rx_valid rises (PAYLOAD_BITS+1)·CYCLES_PER_BIT + HALF_BIT + 3 cycles (±1) after the line's falling edge. This includes the 2-cycle synchroniser and the registered output.

Decomposition:
- Shared package uart_pkg:
  - FSM state encodings: IDLE = 0, START = 1, RECV = 2, STOP = 3, on 3 bits, shared with the transmitter.
  - A constant function computing cycles-per-bit and the counter width.
- Sub-module sync_2ff: the reusable 2-flop synchroniser. Its reset value is a parameter, set to 1 here.
- Everything else stays in one module.

Test Plan (CLK_HZ = 50_000_000, BIT_RATE = 1_000_000 → CYCLES_PER_BIT = 50):
- Single byte 0xA5, 1 stop bit, driven by a bench bit model → uart_rx_valid one cycle, uart_rx_data = 0xA5, uart_rx_break never high; valid within 478±1 cycles of the falling edge.
- Loopback from the transmitter with the same parameters, bytes 0x00, 0xFF, 0x55, 0x3C back-to-back → four valid strobes in order with matching data; no breaks.
- Start glitch: line low for 10 cycles, then high → FSM returns to IDLE at HALF_BIT; no valid; uart_rx_busy high only during the glitch window.
- Frame 0x81 with stop bit forced low → uart_rx_break one cycle, no valid, uart_rx_data keeps its previous value. With the line held low afterwards, no new frame starts until the line goes 1→0 again.
- uart_rx_en = 0 while frame 0x42 is sent → no valid. Set uart_rx_en = 1, send 0x42 → valid with 0x42.
- Assert resetn low in the middle of data bit 3 of 0x99 → all outputs at reset values asynchronously. After release, frame 0x17 is received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helpers,
// common to the receiver and transmitter cores.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    RECV  = 3'd2,
    STOP  = 3'd3
  } uart_state_t;

  // Two-step integer division keeps TX and RX bit periods identical.
  function automatic int calc_cycles_per_bit(input int bit_rate, input int clk_hz);
    return (1_000_000_000 / bit_rate) / (1_000_000_000 / clk_hz);
  endfunction

  function automatic int calc_cnt_width(input int cycles_per_bit);
    return 1 + $clog2(cycles_per_bit);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input bit.
// The reset value is chosen by the instantiating block.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic resetn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rs232_rx.sv
// RS-232 UART receiver: synchronises the line, finds the start edge and
// samples each bit mid-period, delivering bytes with a one-cycle strobe.
module uart_rs232_rx
  import uart_pkg::*;
#(
  parameter int BIT_RATE     = 9600,
  parameter int CLK_HZ       = 48_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int STOP_BITS    = 1
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    uart_rxd,
  input  logic                    uart_rx_en,
  output logic                    uart_rx_break,
  output logic                    uart_rx_valid,
  output logic [PAYLOAD_BITS-1:0] uart_rx_data,
  output logic                    uart_rx_busy
);

  localparam int CYCLES_PER_BIT = calc_cycles_per_bit(BIT_RATE, CLK_HZ);
  localparam int HALF_BIT       = CYCLES_PER_BIT / 2;
  localparam int CNT_W          = calc_cnt_width(CYCLES_PER_BIT);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CYCLES_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [3:0]       LAST_BIT  = 4'(PAYLOAD_BITS - 1);

  if (PAYLOAD_BITS > 15 || PAYLOAD_BITS < 2 || STOP_BITS < 1) begin : g_bad_cfg
    $error("uart_rs232_rx: unsupported PAYLOAD_BITS/STOP_BITS");
  end

  uart_state_t             state, state_nxt;
  logic [CNT_W-1:0]        cyc_cnt, cyc_nxt;
  logic [3:0]              bit_cnt, bit_nxt;
  logic [PAYLOAD_BITS-1:0] shreg, shreg_nxt;
  logic [PAYLOAD_BITS-1:0] data_nxt;
  logic                    valid_nxt, brk_nxt;
  logic                    rxd_s, rxd_hist, fall_edge;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (uart_rxd),
    .q      (rxd_s)
  );

  assign fall_edge    = rxd_hist & ~rxd_s;
  assign uart_rx_busy = (state != IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state         <= IDLE;
      cyc_cnt       <= '0;
      bit_cnt       <= '0;
      shreg         <= '0;
      rxd_hist      <= 1'b1;
      uart_rx_data  <= '0;
      uart_rx_valid <= 1'b0;
      uart_rx_break <= 1'b0;
    end else begin
      state         <= state_nxt;
      cyc_cnt       <= cyc_nxt;
      bit_cnt       <= bit_nxt;
      shreg         <= shreg_nxt;
      rxd_hist      <= rxd_s;
      uart_rx_data  <= data_nxt;
      uart_rx_valid <= valid_nxt;
      uart_rx_break <= brk_nxt;
    end
  end

  // Sample points sit at the end of each counted period; the start bit is
  // counted only to its middle so every later sample lands mid-bit.
  always_comb begin
    state_nxt = state;
    cyc_nxt   = cyc_cnt + CNT_W'(1);
    bit_nxt   = bit_cnt;
    shreg_nxt = shreg;
    data_nxt  = uart_rx_data;
    valid_nxt = 1'b0;
    brk_nxt   = 1'b0;
    case (state)
      IDLE: begin
        cyc_nxt = '0;
        bit_nxt = '0;
        if (fall_edge && uart_rx_en) state_nxt = START;
      end
      START: begin
        if (cyc_cnt == HALF_LAST) begin
          cyc_nxt   = '0;
          state_nxt = rxd_s ? IDLE : RECV;
        end
      end
      RECV: begin
        if (cyc_cnt == BIT_LAST) begin
          cyc_nxt   = '0;
          shreg_nxt = {rxd_s, shreg[PAYLOAD_BITS-1:1]};
          bit_nxt   = bit_cnt + 4'd1;
          if (bit_cnt == LAST_BIT) state_nxt = STOP;
        end
      end
      STOP: begin
        // Leaving mid stop-bit lets a back-to-back start edge be caught.
        if (cyc_cnt == BIT_LAST) begin
          cyc_nxt   = '0;
          state_nxt = IDLE;
          if (rxd_s) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
          end else begin
            brk_nxt = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rs232_rx.sv
// Self-checking bench for uart_rs232_rx at 50 MHz / 1 Mbit/s, with a
// behavioural line driver and a frame-level expectation model.
module tb_uart_rs232_rx;

  localparam int CLK_HZ   = 50_000_000;
  localparam int BIT_RATE = 1_000_000;
  localparam int CPB      = 50;
  localparam int LAT      = (8 + 1) * CPB + CPB / 2 + 3;

  logic       clk        = 1'b0;
  logic       resetn     = 1'b1;
  logic       uart_rxd   = 1'b1;
  logic       uart_rx_en = 1'b1;
  logic       uart_rx_break;
  logic       uart_rx_valid;
  logic [7:0] uart_rx_data;
  logic       uart_rx_busy;

  always #10 clk = ~clk;

  uart_rs232_rx #(
    .BIT_RATE     (BIT_RATE),
    .CLK_HZ       (CLK_HZ),
    .PAYLOAD_BITS (8),
    .STOP_BITS    (1)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .uart_rxd      (uart_rxd),
    .uart_rx_en    (uart_rx_en),
    .uart_rx_break (uart_rx_break),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_busy  (uart_rx_busy)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] got_q[$];
  int         got_cyc_q[$];
  int         brk_cnt;
  logic [7:0] exp_q[$];
  int         exp_brk;
  int         fall_q[$];
  logic [7:0] model_data;
  int         n_checks = 0;
  int         n_errors = 0;

  // Observed strobes, sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (uart_rx_valid) begin
      got_q.push_back(uart_rx_data);
      got_cyc_q.push_back(cyc);
    end
    if (uart_rx_break) brk_cnt++;
  end

  task automatic clear_logs();
    got_q.delete();
    got_cyc_q.delete();
    exp_q.delete();
    fall_q.delete();
    brk_cnt = 0;
    exp_brk = 0;
  endtask

  // Drives one 8N1 frame; the line is left at the stop-bit level afterwards.
  task automatic send_frame(input logic [7:0] b, input bit stop_val, input bit modeled);
    logic [9:0] bits;
    bits = {stop_val, b, 1'b0};
    if (modeled && uart_rx_en) begin
      if (stop_val) begin
        exp_q.push_back(b);
        model_data = b;
      end else begin
        exp_brk++;
      end
    end
    fall_q.push_back(cyc);
    for (int i = 0; i < 10; i++) begin
      uart_rxd = bits[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #5 resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (uart_rx_data !== 8'h00) begin n_errors++; $display("FAIL reset_data got %h want 00", uart_rx_data); end
    n_checks++;
    if (uart_rx_valid !== 1'b0) begin n_errors++; $display("FAIL reset_valid got %b want 0", uart_rx_valid); end
    n_checks++;
    if (uart_rx_break !== 1'b0) begin n_errors++; $display("FAIL reset_break got %b want 0", uart_rx_break); end
    n_checks++;
    if (uart_rx_busy !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", uart_rx_busy); end
    resetn = 1'b1;
    model_data = 8'h00;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int lat;
    clear_logs();
    send_frame(8'hA5, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 1) begin n_errors++; $display("FAIL single_count got %0d want 1", got_q.size()); end
    if (got_q.size() >= 1) begin
      n_checks++;
      if (got_q[0] !== exp_q[0]) begin n_errors++; $display("FAIL single_data got %h want %h", got_q[0], exp_q[0]); end
      lat = got_cyc_q[0] - fall_q[0];
      n_checks++;
      if (lat < LAT - 1 || lat > LAT + 1) begin n_errors++; $display("FAIL single_latency got %0d want %0d+-1", lat, LAT); end
    end
    n_checks++;
    if (brk_cnt !== 0) begin n_errors++; $display("FAIL single_break got %0d want 0", brk_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] fixed [4];
    fixed = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    clear_logs();
    for (int i = 0; i < 4; i++) send_frame(fixed[i], 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b1);
      repeat ($urandom_range(0, 20)) @(negedge clk);
    end
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin
      n_errors++; $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_checks++;
      if (got_q[i] !== exp_q[i]) begin n_errors++; $display("FAIL b2b_data[%0d] got %h want %h", i, got_q[i], exp_q[i]); end
    end
    n_checks++;
    if (brk_cnt !== exp_brk) begin n_errors++; $display("FAIL b2b_break got %0d want %0d", brk_cnt, exp_brk); end
  endtask

  task automatic test_glitch();
    clear_logs();
    uart_rxd = 1'b0;
    repeat (10) @(negedge clk);
    uart_rxd = 1'b1;
    repeat (5) @(negedge clk);
    n_checks++;
    if (uart_rx_busy !== 1'b1) begin n_errors++; $display("FAIL glitch_busy_high got %b want 1", uart_rx_busy); end
    repeat (25) @(negedge clk);
    n_checks++;
    if (uart_rx_busy !== 1'b0) begin n_errors++; $display("FAIL glitch_busy_low got %b want 0", uart_rx_busy); end
    repeat (500) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0 || brk_cnt !== 0) begin
      n_errors++; $display("FAIL glitch_strobe got valid=%0d break=%0d want 0/0", got_q.size(), brk_cnt);
    end
  endtask

  task automatic test_break();
    logic [7:0] prev;
    int         busy_cycles;
    clear_logs();
    prev = model_data;
    send_frame(8'h81, 1'b0, 1'b1);
    busy_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (uart_rx_busy) busy_cycles++;
    end
    n_checks++;
    if (brk_cnt !== exp_brk) begin n_errors++; $display("FAIL break_count got %0d want %0d", brk_cnt, exp_brk); end
    n_checks++;
    if (got_q.size() !== 0) begin n_errors++; $display("FAIL break_valid got %0d want 0", got_q.size()); end
    n_checks++;
    if (uart_rx_data !== prev) begin n_errors++; $display("FAIL break_data_hold got %h want %h", uart_rx_data, prev); end
    n_checks++;
    if (busy_cycles !== 0) begin n_errors++; $display("FAIL break_stuck_low_busy got %0d want 0", busy_cycles); end
    uart_rxd = 1'b1;
    repeat (20) @(negedge clk);
    clear_logs();
    send_frame(8'h81, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 1 || uart_rx_data !== 8'h81) begin
      n_errors++; $display("FAIL break_recover got count=%0d data=%h want 1/81", got_q.size(), uart_rx_data);
    end
  endtask

  task automatic test_enable();
    clear_logs();
    uart_rx_en = 1'b0;
    send_frame(8'h42, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0) begin n_errors++; $display("FAIL en_off_valid got %0d want 0", got_q.size()); end
    uart_rx_en = 1'b1;
    send_frame(8'h42, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== exp_q.size()) begin n_errors++; $display("FAIL en_on_count got %0d want %0d", got_q.size(), exp_q.size()); end
    n_checks++;
    if (uart_rx_data !== model_data) begin n_errors++; $display("FAIL en_on_data got %h want %h", uart_rx_data, model_data); end
  endtask

  task automatic test_reset_midframe();
    clear_logs();
    fork
      send_frame(8'h99, 1'b1, 1'b0);
      begin
        repeat (225) @(negedge clk);
        resetn = 1'b0;
        #1;
        n_checks++;
        if (uart_rx_busy !== 1'b0 || uart_rx_valid !== 1'b0 || uart_rx_break !== 1'b0 || uart_rx_data !== 8'h00) begin
          n_errors++;
          $display("FAIL midreset_outputs got busy=%b valid=%b break=%b data=%h want 0/0/0/00",
                   uart_rx_busy, uart_rx_valid, uart_rx_break, uart_rx_data);
        end
      end
    join
    model_data = 8'h00;
    repeat (10) @(negedge clk);
    resetn = 1'b1;
    repeat (10) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 0) begin n_errors++; $display("FAIL midreset_valid got %0d want 0", got_q.size()); end
    send_frame(8'h17, 1'b1, 1'b1);
    repeat (30) @(negedge clk);
    n_checks++;
    if (got_q.size() !== 1 || uart_rx_data !== model_data) begin
      n_errors++; $display("FAIL midreset_recover got count=%0d data=%h want 1/%h", got_q.size(), uart_rx_data, model_data);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_break();
    test_enable();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
